// File: rtl/gcd_result_bcd_if.sv
// Result bus between the GCD processor and its BCD display consumer.
// The seg field exists only when GCD_BCD_SEG7_EN is defined.
interface gcd_result_bcd_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  halt;
  logic [WIDTH-1:0]      dataIn;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [1:0]            dbg_state;
`ifdef GCD_BCD_SEG7_EN
  logic [7*DIGITS-1:0]   seg;
`endif

  // Handshake: the master raises halt with dataIn valid. The rising edge of halt is a
  // one-shot request that is taken only while busy is low, and there is no ready-style
  // back-pressure. done pulses for one cycle when bcd (and seg) have just been updated.
`ifdef GCD_BCD_SEG7_EN
  modport master (output halt, dataIn, input busy, done, bcd, dbg_state, seg);
  modport slave  (input halt, dataIn, output busy, done, bcd, dbg_state, seg);
`else
  modport master (output halt, dataIn, input busy, done, bcd, dbg_state);
  modport slave  (input halt, dataIn, output busy, done, bcd, dbg_state);
`endif
endinterface

// File: rtl/gcd_result_bcd.sv
// Sequential double-dabble converter for the GCD result, with an optional 7-segment
// decode that is enabled by defining GCD_BCD_SEG7_EN.
module gcd_result_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic             clock,
  input  logic             reset,
  gcd_result_bcd_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;

  state_e          state_q;
  logic            halt_q;
  logic            busy_q;
  logic            done_q;
  logic [WIDTH-1:0] shift_q;
  logic [SW-1:0]   scratch_q;
  logic [SW-1:0]   bcd_q;
  logic [CW-1:0]   cnt_q;
  logic            trig;
  logic [SW-1:0]   adj;
  logic [SW+WIDTH-1:0] shifted_d;

  assign trig = bus.halt & ~halt_q;

  // The add-3 correction uses the pre-shift nibbles; the carry out of the top nibble falls off.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    shifted_d = {adj, shift_q} << 1;
  end

`ifdef GCD_BCD_SEG7_EN
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  logic [7*DIGITS-1:0] seg_q;
  logic [7*DIGITS-1:0] seg_d;
  logic                lead;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  // Blank zero digits from the top down until the first non-zero; units always shown.
  always_comb begin
    seg_d = '1;
    lead  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (i != 0 && lead && scratch_q[4*i +: 4] == 4'd0) begin
        seg_d[7*i +: 7] = SEG_BLANK;
      end else begin
        seg_d[7*i +: 7] = glyph(scratch_q[4*i +: 4]);
        lead = 1'b0;
      end
    end
  end

  assign bus.seg = seg_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      halt_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
`ifdef GCD_BCD_SEG7_EN
      seg_q     <= {{(7*(DIGITS-1)){1'b1}}, SEG_ZERO};
`endif
    end else begin
      halt_q <= bus.halt;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trig) begin
            shift_q   <= bus.dataIn;
            scratch_q <= '0;
            cnt_q     <= CW'(WIDTH);
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch_q, shift_q} <= shifted_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= DONE;
        end
        DONE: begin
          bcd_q   <= scratch_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifdef GCD_BCD_SEG7_EN
          seg_q   <= seg_d;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bcd       = bcd_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_gcd_result_bcd.sv
// Directed bench for gcd_result_bcd; seg checks are active when GCD_BCD_SEG7_EN is defined.
module tb_gcd_result_bcd;
  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   done_cnt;
  int   base;
  int   k;

  gcd_result_bcd_if #(.WIDTH(8), .DIGITS(3)) bus ();

  gcd_result_bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (bus.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits up to 20 edges after E0 for done; k is the edge index, or 0 when it never comes.
  task automatic wait_done(output int kk);
    kk = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        kk = i;
        break;
      end
    end
  endtask

  // Driver: halt low for a cycle, then rising with val; checks latency and result.
  task automatic run_conv(input string tag, input logic [7:0] val, input logic [11:0] exp_bcd);
    int kk;
    bus.halt = 1'b0;
    tick();
    bus.dataIn = val;
    bus.halt   = 1'b1;
    tick();
    check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
    wait_done(kk);
    check({tag, "_latency"}, 32'(kk), 32'd9);
    check({tag, "_bcd"}, 32'(bus.bcd), 32'(exp_bcd));
    check({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
    tick();
    check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    reset      = 1'b1;
    bus.halt   = 1'b0;
    bus.dataIn = 8'd0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    tick();

    check("rst_bcd", 32'(bus.bcd), 32'h000);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
`ifdef GCD_BCD_SEG7_EN
    check("rst_seg", 32'(bus.seg), 32'({7'b1111111, 7'b1111111, 7'b1000000}));
`endif

    run_conv("v10", 8'd10, 12'h010);
    run_conv("v255", 8'd255, 12'h255);
    run_conv("v0a", 8'd0, 12'h000);
    run_conv("v0b", 8'd0, 12'h000);

    // halt held high for 40 cycles: a single conversion only
    base = done_cnt;
    run_conv("v37", 8'd37, 12'h037);
    repeat (40) tick();
    check("hold_done_count", 32'(done_cnt - base), 32'd1);
    check("hold_bcd", 32'(bus.bcd), 32'h037);
    check("hold_busy", 32'(bus.busy), 32'd0);

    // second rising edge while busy is ignored; dataIn change has no effect
    bus.halt = 1'b0;
    tick();
    base = done_cnt;
    bus.dataIn = 8'd50;
    bus.halt   = 1'b1;
    tick();
    tick();
    bus.halt = 1'b0;
    tick();
    tick();
    bus.halt   = 1'b1;
    bus.dataIn = 8'd99;
    wait_done(k);
    check("busy_edge_seen", 32'(k != 0), 32'd1);
    check("busy_edge_bcd", 32'(bus.bcd), 32'h050);
    repeat (20) tick();
    check("busy_edge_done_count", 32'(done_cnt - base), 32'd1);
    check("busy_edge_final_bcd", 32'(bus.bcd), 32'h050);

    // reset mid-conversion aborts with no trailing done
    bus.halt = 1'b0;
    tick();
    bus.dataIn = 8'd123;
    bus.halt   = 1'b1;
    tick();
    repeat (4) tick();
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    base = done_cnt;
    reset    = 1'b1;
    bus.halt = 1'b0;
    #1;
    check("abort_bcd", 32'(bus.bcd), 32'h000);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    tick();
    reset = 1'b0;
    repeat (15) tick();
    check("abort_no_done", 32'(done_cnt - base), 32'd0);
    check("abort_idle_bcd", 32'(bus.bcd), 32'h000);
    run_conv("v123", 8'd123, 12'h123);

`ifdef GCD_BCD_SEG7_EN
    run_conv("seg7", 8'd7, 12'h007);
    check("seg_7", 32'(bus.seg), 32'({7'b1111111, 7'b1111111, 7'b1111000}));
    run_conv("seg105", 8'd105, 12'h105);
    check("seg_105", 32'(bus.seg), 32'({7'b1111001, 7'b1000000, 7'b0010010}));
    run_conv("seg40", 8'd40, 12'h040);
    check("seg_40", 32'(bus.seg), 32'({7'b1111111, 7'b0011001, 7'b1000000}));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gcd_result_bcd.md
Name: gcd_result_bcd

Overview:
- Downstream consumer of the GCD processor's result bus.
- Waits for the processor's halt to rise, samples the 8-bit result, and converts it from binary to packed BCD using a sequential double-dabble (shift-add-3) engine.
- Holds the BCD digits stable for the board display logic and issues a one-cycle done strobe per conversion.

Parameters:
- WIDTH, 8, width of the binary result input.
- DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1. Not checked in RTL; excess high bits are lost.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- halt  input  1  processor halt flag; its rising edge requests a conversion.
- dataIn  input  WIDTH  processor result (dataOut of the processor).
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd has just been updated.
- bcd  output  4*DIGITS  packed BCD result; digit 0 (units) is in bits [3:0].
- seg  output  7*DIGITS  present only with GCD_BCD_SEG7_EN; see Optional Feature.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, bcd=0, halt_q=0, shift/scratch registers=0, counter=0.
- Edge detect: halt_q registers halt every cycle. trig = halt & ~halt_q.
  - halt already high when reset releases therefore triggers exactly one conversion.
- States and transitions:
  - IDLE: busy=0. When trig=1 at edge E0: shift register <= dataIn, BCD scratch <= 0, counter <= WIDTH, go to SHIFT.
  - SHIFT: busy=1. Each edge, every scratch nibble >= 5 gets +3 (all nibbles in parallel, on the pre-shift value). Then {scratch, shift} shifts left one bit and counter decrements. At the edge where counter goes 1->0, go to DONE.
  - DONE: busy=1. At the next edge: bcd <= scratch, done <= 1, go to IDLE.
- Timing: the capture edge is E0. Shift edges are E1..E(WIDTH). bcd and done update at E(WIDTH+1), giving a latency of WIDTH+1 cycles from capture (9 for defaults). done is high for exactly one cycle.
- bcd holds its last value until the next conversion completes. It never shows partial results.
- trig while busy (SHIFT or DONE) is ignored: no queueing, no restart. halt_q still tracks halt.
- halt held high for any duration produces one conversion only. A new conversion needs halt to fall and then rise again.
- dataIn is sampled only at E0; later changes have no effect on the conversion in flight.
- Reset asserted mid-conversion aborts immediately: bcd=0, done=0, busy=0, and no done pulse follows.
- Scratch width is 4*DIGITS. Any carry out of the top nibble is discarded.

Optional Feature:
- Macro: GCD_BCD_SEG7_EN.
- When defined:
  - The seg port exists, registered and updated on the same edge as bcd.
  - Per digit, 7 bits {g,f,e,d,c,b,a}, active-low; digit i occupies bits [7i+6:7i].
  - Standard 0-9 glyphs; nibbles 10-15 display blank (7'b1111111).
  - Leading-zero blanking: higher digits that are 0 and have only zeros above them are blank. The units digit is always shown.
  - Reset value: all digits blank except units, which shows "0" (7'b1000000).
- When undefined: the seg port and its decode logic are absent. Everything else is identical.

Test Plan:
- Reset released, halt=0, dataIn=8'd10, then halt 0->1 -> busy rises after E0; bcd=12'h010 and done=1 for one cycle exactly 9 cycles after capture; busy=0 afterwards.
- dataIn=8'd255, halt rising -> bcd=12'h255. Then dataIn=8'd0 with a new halt 0->1->0->1 sequence -> bcd=12'h000 on the second done.
- halt held high for 40 cycles with dataIn=8'd37 -> exactly one done pulse, bcd=12'h037, no further activity.
- halt rising, then halt low and high again 3 cycles later while busy, dataIn changed to 99 -> the second edge is ignored; single done with the value captured at E0.
- Conversion of 8'd123 started, reset pulsed at cycle 4 -> bcd=0, busy=0, done stays 0. A post-reset halt rising with 8'd123 -> bcd=12'h123.
- GCD_BCD_SEG7_EN defined, dataIn=8'd7 -> seg digit0=7'b1111000, digits 1 and 2 = 7'b1111111. dataIn=8'd105 -> digits {1,0,5} with the middle zero shown as 7'b1000000.
